bcd_to_bin: RTL and testbench
=============================

BCD_TO_BIN -- requirements
Module: bcd_to_bin

Interface
REQ-001 The block SHALL have parameter DIGITS, default 3, giving the number of packed BCD input digits.
REQ-002 The block SHALL have parameter BIN_W, default 10, giving the binary output width; BIN_W SHALL be >= ceil(log2(10^DIGITS)).
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, reset that is synchronous and active-high.
REQ-005 The block SHALL have port start, input, 1, a request to convert bcd_in.
REQ-006 The block SHALL have port bcd_in, input, 4*DIGITS, packed BCD with the least significant digit in bits [3:0].
REQ-007 The block SHALL have port bin_out, output, BIN_W, the binary result of the last completed conversion.
REQ-008 The block SHALL have port busy, output, 1, high while a request is in progress.
REQ-009 The block SHALL have port done, output, 1, a one-cycle completion pulse.
REQ-010 The block SHALL have port err, output, 1, high when the last request held an invalid digit.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, CONVERT and DONE.
REQ-012 In IDLE with start=1, the block SHALL capture bcd_in at that edge; input changes after capture SHALL NOT affect the result.
REQ-013 At capture, if any digit exceeds 9 (4'hA-4'hF), the next state SHALL be DONE with err=1 and bin_out=0; otherwise the next state SHALL be CONVERT with err=0.
REQ-014 Conversion SHALL use reverse double-dabble on a working register of the BCD field concatenated above a BIN_W binary field.
REQ-015 In each CONVERT cycle, the block SHALL shift the working register right by 1, then subtract 3 from every BCD digit that is >= 8.
REQ-016 An iteration counter SHALL advance once per CONVERT cycle, and exactly BIN_W shift/correct iterations SHALL be performed.
REQ-017 After the BIN_W-th iteration, the next state SHALL be DONE and bin_out SHALL load the binary field.
REQ-018 Latency SHALL be fixed: done is high in the cycle after edge BIN_W counted from the capture edge (edge 0), which is 10 clocks for the defaults.
REQ-019 On the invalid-digit path, done SHALL be high in the cycle after the capture edge.
REQ-020 DONE SHALL last exactly one cycle; done=1 only in DONE; the next state SHALL always be IDLE.
REQ-021 busy SHALL be 1 in CONVERT and in DONE, and 0 in IDLE.
REQ-022 start SHALL be ignored while busy=1 (no re-capture, no effect on the conversion in progress).
REQ-023 start held high continuously SHALL produce back-to-back conversions, each recaptured in IDLE.
REQ-024 bin_out and err SHALL hold their values from the end of one request until DONE of the next accepted request.
REQ-025 The block SHALL produce no overflow: all valid inputs (0 to 10^DIGITS-1) SHALL fit in BIN_W bits.

Reset
REQ-026 While rst=1 at a clock edge, the state SHALL be IDLE, the iteration counter and working register SHALL be 0, and bin_out=0, busy=0, done=0, err=0.
REQ-027 Reset SHALL take priority over start.
REQ-028 Reset asserted mid-CONVERT SHALL abort the conversion with no done pulse, and bin_out SHALL read 0 afterwards.
REQ-029 After rst deasserts, the first start SHALL be accepted at the next edge.

Verification
REQ-030 The bench SHALL check: bcd_in=12'h025 with start pulse -> done 10 clocks later, bin_out=10'd25 (binary 11001), err=0.
REQ-031 The bench SHALL check: bcd_in=12'h078 -> bin_out=10'd78; then 12'h999 -> bin_out=10'd999; then 12'h000 -> bin_out=0, each with one done pulse.
REQ-032 The bench SHALL check: bcd_in=12'h0A5 -> done 1 clock after capture, err=1, bin_out=0; a following 12'h012 -> err=0, bin_out=12.
REQ-033 The bench SHALL check: start re-pulsed with bcd_in=12'h500 during the 12'h321 conversion -> single result 321, and the second request is ignored.
REQ-034 The bench SHALL check: rst pulsed 4 cycles into the 12'h456 conversion -> no done, busy=0, bin_out=0; a new 12'h456 request -> 456.
REQ-035 The bench SHALL check: all 1000 valid inputs 000-999 in a sweep -> bin_out equals the decimal value, latency is constant, and err=0.

Source files
------------

// File: rtl/bcd_to_bin.sv
// Sequential BCD-to-binary converter using reverse double-dabble.
// One bit of the binary result is shifted out of the BCD field per CONVERT cycle.
module bcd_to_bin #(
  parameter int DIGITS = 3,
  parameter int BIN_W  = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic [BIN_W-1:0]      bin_out,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int BCD_W  = 4 * DIGITS;
  localparam int WORK_W = BCD_W + BIN_W;
  localparam int CNT_W  = $clog2(BIN_W + 1);

  typedef enum logic [1:0] {
    IDLE,
    CONVERT,
    DONE
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [WORK_W-1:0]   r_work;
  logic [WORK_W-1:0]   w_work_step;
  logic [CNT_W-1:0]    r_cnt;
  logic                w_bcd_ok;
  logic                w_last;

  // True when every nibble of the packed field is a legal decimal digit.
  function automatic logic bcd_valid(input logic [BCD_W-1:0] v);
    logic ok;
    ok = 1'b1;
    for (int d = 0; d < DIGITS; d++) begin
      if (v[4*d +: 4] > 4'd9) ok = 1'b0;
    end
    return ok;
  endfunction

  // One reverse double-dabble iteration: shift right, then pull every digit
  // that received a carried-in half (>= 8) back into the 0-9 range.
  function automatic logic [WORK_W-1:0] dabble_step(input logic [WORK_W-1:0] w);
    logic [WORK_W-1:0] s;
    s = w >> 1;
    for (int d = 0; d < DIGITS; d++) begin
      if (s[BIN_W + 4*d +: 4] >= 4'd8)
        s[BIN_W + 4*d +: 4] = s[BIN_W + 4*d +: 4] - 4'd3;
    end
    return s;
  endfunction

  assign w_bcd_ok    = bcd_valid(bcd_in);
  assign w_work_step = dabble_step(r_work);
  assign w_last      = (r_cnt == CNT_W'(BIN_W - 1));

  assign busy = (r_state != IDLE);
  assign done = (r_state == DONE);

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start) w_state_nxt = w_bcd_ok ? CONVERT : DONE;
      CONVERT: if (w_last) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Results are only rewritten on completion so they hold between requests.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_work  <= '0;
      r_cnt   <= '0;
      bin_out <= '0;
      err     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_cnt <= '0;
            if (w_bcd_ok) begin
              r_work <= {bcd_in, {BIN_W{1'b0}}};
            end else begin
              r_work  <= '0;
              bin_out <= '0;
              err     <= 1'b1;
            end
          end
        end
        CONVERT: begin
          r_work <= w_work_step;
          r_cnt  <= r_cnt + 1'b1;
          if (w_last) begin
            bin_out <= w_work_step[BIN_W-1:0];
            err     <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_to_bin.sv
// Self-checking bench for bcd_to_bin: directed cases, full 000-999 sweep and
// randomized requests compared against a plain-arithmetic decimal model.
module tb_bcd_to_bin;

  localparam int DIGITS = 3;
  localparam int BIN_W  = 10;

  logic              clk;
  logic              rst;
  logic              start;
  logic [11:0]       bcd_in;
  logic [BIN_W-1:0]  bin_out;
  logic              busy;
  logic              done;
  logic              err;

  int n_total = 0;
  int n_bad   = 0;

  bcd_to_bin #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .bcd_in  (bcd_in),
    .bin_out (bin_out),
    .busy    (busy),
    .done    (done),
    .err     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  // Decimal meaning of a packed BCD word, computed digit by digit.
  task automatic ref_model(input logic [11:0] v, output int val, output bit bad);
    int dig;
    val = 0;
    bad = 1'b0;
    for (int d = 0; d < DIGITS; d++) begin
      dig = int'((v >> (4*d)) & 12'hF);
      if (dig > 9) bad = 1'b1;
      val += dig * (10 ** d);
    end
    if (bad) val = 0;
  endtask

  // Leaves the bench at the negedge right after the capture edge (edge 0).
  task automatic launch(input logic [11:0] v);
    @(negedge clk);
    bcd_in = v;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
  endtask

  task automatic wait_done(input int k0, output int k);
    k = k0;
    while (!done && k < 40) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic check_result(input logic [11:0] v, input int k, input string tag);
    int  val;
    bit  bad;
    ref_model(v, val, bad);
    chk({tag, "_lat"}, 32'(k), bad ? 32'd0 : 32'(BIN_W));
    chk({tag, "_bin"}, 32'(bin_out), 32'(val));
    chk({tag, "_err"}, 32'(err), 32'(bad));
    @(negedge clk);
    chk({tag, "_pulse"}, 32'(done), 32'd0);
  endtask

  task automatic run_check(input logic [11:0] v, input string tag);
    int k;
    launch(v);
    wait_done(0, k);
    check_result(v, k, tag);
  endtask

  initial begin
    int          k;
    int          k2;
    int          seen;
    logic [11:0] v;

    rst    = 1'b1;
    start  = 1'b1;
    bcd_in = 12'h025;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err",  32'(err),  32'd0);
    chk("rst_bin",  32'(bin_out), 32'd0);

    // start already high as reset drops: accepted at the very next edge
    rst = 1'b0;
    @(negedge clk);
    start = 1'b0;
    chk("cap_busy", 32'(busy), 32'd1);
    bcd_in = 12'h999;
    wait_done(0, k);
    check_result(12'h025, k, "h025");

    run_check(12'h078, "h078");
    run_check(12'h999, "h999");
    run_check(12'h000, "h000");
    run_check(12'h0A5, "h0A5");
    run_check(12'h012, "h012");

    // second request during a conversion must be ignored
    launch(12'h321);
    bcd_in = 12'h500;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(2, k);
    check_result(12'h321, k, "h321_ign");
    chk("ign_idle", 32'(busy), 32'd0);

    // reset four cycles into a conversion
    launch(12'h456);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_bin",  32'(bin_out), 32'd0);
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      if (done) seen++;
      @(negedge clk);
    end
    chk("abort_nodone", 32'(seen), 32'd0);
    run_check(12'h456, "h456");

    // start held high: back-to-back conversions spaced BIN_W+2 edges apart
    @(negedge clk);
    bcd_in = 12'h123;
    start  = 1'b1;
    @(negedge clk);
    wait_done(0, k);
    chk("b2b_lat1", 32'(k), 32'(BIN_W));
    chk("b2b_bin1", 32'(bin_out), 32'd123);
    @(negedge clk);
    wait_done(k + 1, k2);
    start = 1'b0;
    chk("b2b_gap", 32'(k2 - k), 32'(BIN_W + 2));
    chk("b2b_bin2", 32'(bin_out), 32'd123);
    @(negedge clk);

    for (int n = 0; n < 1000; n++) begin
      v = {4'(n / 100), 4'((n / 10) % 10), 4'(n % 10)};
      run_check(v, "sweep");
    end

    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 3) == 0) v = 12'($urandom_range(0, 4095));
      else v = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run_check(v, "rand");
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
